// File: rtl/fwd_pkg.sv
// fwd_pkg: shared select codes, FSM encoding and register constants for forwarding
package fwd_pkg;
  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  typedef enum logic {RUN = 1'b0, LU = 1'b1} state_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: compares one ID source against one shadow stage destination
module fwd_match
  import fwd_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  logic [4:0] rw_i,
  input  logic       wr_i,
  output logic       match_o
);
  assign match_o = use_i & wr_i & (rw_i == src_i) & (src_i != REG_ZERO);
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding selects and load-use stall/bubble control
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       dRw,
  input  logic             dRegWrite,
  input  logic             dMemToReg,
  output logic [1:0]       aluselectA,
  output logic [1:0]       aluselectB,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);
  state_t           state_q, state_d;
  logic [4:0]       ex_rw_q, mem_rw_q;
  logic             ex_wr_q, ex_ld_q, mem_wr_q;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic             a_ex, a_mem, b_ex, b_mem, hazard;

  fwd_match u_a_ex  (.src_i(id_rs), .use_i(id_use_rs), .rw_i(ex_rw_q),  .wr_i(ex_wr_q),  .match_o(a_ex));
  fwd_match u_a_mem (.src_i(id_rs), .use_i(id_use_rs), .rw_i(mem_rw_q), .wr_i(mem_wr_q), .match_o(a_mem));
  fwd_match u_b_ex  (.src_i(id_rt), .use_i(id_use_rt), .rw_i(ex_rw_q),  .wr_i(ex_wr_q),  .match_o(b_ex));
  fwd_match u_b_mem (.src_i(id_rt), .use_i(id_use_rt), .rw_i(mem_rw_q), .wr_i(mem_wr_q), .match_o(b_mem));

  assign hazard = ex_ld_q & (a_ex | b_ex);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a load-use always costs exactly one LU cycle
  always_comb begin
    state_d = (state_q == RUN && hazard) ? LU : RUN;
  end

  // FSM outputs: stall and bubble are the same combinational hazard decode
  always_comb begin
    stall  = (state_q == RUN) & hazard;
    bubble = stall;
  end

  // Next selects (youngest producer wins) and saturating counter updates
  always_comb begin
    sel_a_d     = stall ? SEL_REG : a_ex ? SEL_EXMEM : a_mem ? SEL_MEMWB : SEL_REG;
    sel_b_d     = stall ? SEL_REG : b_ex ? SEL_EXMEM : b_mem ? SEL_MEMWB : SEL_REG;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall & ~&stall_cnt_q};
    fwd_cnt_d   = fwd_cnt_q + {{(CNT_W-1){1'b0}}, ((sel_a_d != SEL_REG) | (sel_b_d != SEL_REG)) & ~&fwd_cnt_q};
  end

  // Shadow EX/MEM destinations, registered selects and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rw_q     <= REG_ZERO;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_rw_q    <= REG_ZERO;
      mem_wr_q    <= 1'b0;
      sel_a_q     <= SEL_REG;
      sel_b_q     <= SEL_REG;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      ex_rw_q     <= dRw;
      ex_wr_q     <= dRegWrite & ~bubble;
      ex_ld_q     <= dMemToReg & ~bubble;
      mem_rw_q    <= ex_rw_q;
      mem_wr_q    <= ex_wr_q;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign aluselectA = sel_a_q;
  assign aluselectB = sel_b_q;
  assign stall_cnt  = stall_cnt_q;
  assign fwd_cnt    = fwd_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects, load-use stall and counters
module tb_fwd_hazard_unit;
  localparam int CNT_W = 3;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, dRw;
  logic             id_use_rs, id_use_rt, dRegWrite, dMemToReg;
  logic [1:0]       aluselectA, aluselectB;
  logic             stall, bubble;
  logic [CNT_W-1:0] stall_cnt, fwd_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  fwd_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .dRw(dRw),
    .dRegWrite(dRegWrite), .dMemToReg(dMemToReg),
    .aluselectA(aluselectA), .aluselectB(aluselectB),
    .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // present an instruction in ID and let combinational outputs settle
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] rw, input logic wr, input logic ld);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    dRw = rw; dRegWrite = wr; dMemToReg = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  // lw $4 followed by add reading $4: one stall cycle, then LU
  task automatic load_use();
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(5'd4, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    tick();
    nop();
    nop();
  endtask

  initial begin
    rst_n = 1'b0;
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #12;
    chk("rst_selA", aluselectA, 0);
    chk("rst_selB", aluselectB, 0);
    chk("rst_stall", stall, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwd_cnt", fwd_cnt, 0);
    rst_n = 1'b1;
    tick();
    // back-to-back: add $3 ; sub reads $3 on rs
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    issue(5'd3, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("b2b_stall", stall, 0);
    tick();
    chk("b2b_selA", aluselectA, 1);
    chk("b2b_selB", aluselectB, 0);
    chk("b2b_fwd_cnt", fwd_cnt, 1);
    nop(); nop();
    // two ahead: add $5 ; add $11 ; or reads $5 on rt
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    tick();
    issue(5'd12, 5'd5, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    tick();
    chk("two_selA", aluselectA, 0);
    chk("two_selB", aluselectB, 2);
    nop(); nop();
    // both stages write $7: youngest wins
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    issue(5'd7, 5'd7, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    tick();
    chk("both_selA", aluselectA, 1);
    chk("both_selB", aluselectB, 1);
    chk("both_fwd_cnt", fwd_cnt, 3);
    nop(); nop();
    // load-use
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(5'd4, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble, 1);
    tick();
    chk("lu_stall_once", stall, 0);
    chk("lu_bubble_once", bubble, 0);
    chk("lu_selA_hold", aluselectA, 0);
    tick();
    chk("lu_selA", aluselectA, 2);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_fwd_cnt", fwd_cnt, 4);
    nop(); nop();
    // $0 never forwards
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0);
    tick();
    chk("zero_selA", aluselectA, 0);
    chk("zero_selB", aluselectB, 0);
    nop(); nop();
    // rt unused (immediate) does not forward
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    issue(5'd1, 5'd6, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0);
    tick();
    chk("imm_selB", aluselectB, 0);
    chk("imm_fwd_cnt", fwd_cnt, 4);
    nop(); nop();
    // reset asserted during the LU cycle
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(5'd4, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    chk("rlu_stall_pre", stall, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rlu_stall", stall, 0);
    chk("rlu_bubble", bubble, 0);
    chk("rlu_stall_cnt", stall_cnt, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rlu_selA", aluselectA, 0);
    chk("rlu_fwd_cnt", fwd_cnt, 0);
    chk("rlu_stall_after", stall, 0);
    nop(); nop();
    // saturation of stall_cnt
    for (int i = 0; i < 6; i++) load_use();
    chk("sat_pre", stall_cnt, 6);
    load_use();
    chk("sat_max", stall_cnt, 7);
    load_use();
    chk("sat_hold", stall_cnt, 7);
    chk("sat_fwd", fwd_cnt, 7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
